rr_sample_mux: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with a built-in select sequencer and a valid/ready output.
- Generalises the fixed 4:1 single-bit mux with an externally counted select.
- Steps through enabled channels in round-robin order, or holds a channel, or jumps to a loaded index.
- Presents one registered sample per handshake. Sits between raw channel inputs and a downstream sample consumer.

---
 rtl/rr_sample_mux_pkg.sv | 15 +
 rtl/rr_sample_mux_if.sv | 27 ++
 rtl/rr_sample_mux_next.sv | 51 +++++
 rtl/rr_sample_mux.sv | 142 ++++++++++++++
 tb/tb_rr_sample_mux.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_sample_mux_pkg.sv
// rr_sample_mux shared definitions:
// mode encodings and sequencer FSM states.
package rr_sample_mux_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_sample_mux_if.sv
// rr_sample_mux output stream:
// registered sample with valid/ready handshake.
interface rr_sample_mux_if #(
  parameter int W  = 1,
  parameter int SW = 1
);

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;

  modport master (
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

endinterface

// File: rtl/rr_sample_mux_next.sv
// rr_next_sel: next enabled channel after i_cur,
// found by rotating the mask and priority-encoding.
module rr_next_sel #(
  parameter  int NCH = 4,
  localparam int SW  = $clog2(NCH)
) (
  input  logic [SW-1:0]  i_cur,
  input  logic [NCH-1:0] i_en,
  output logic [SW-1:0]  o_next,
  output logic           o_wrap,
  output logic           o_none
);

  logic [NCH-1:0] w_rot;
  logic [SW-1:0]  w_off;

  function automatic logic [SW-1:0] f_add(
    input logic [SW-1:0] a,
    input int            b
  );
    int s;
    s = (int'(a) + b) % NCH;
    return SW'(s);
  endfunction

  // bit k of w_rot is channel (cur+1+k) mod NCH;
  // the lowest set bit is the next channel
  always_comb begin
    w_rot = '0;
    w_off = '0;
    for (int k = 0; k < NCH; k++) begin
      w_rot[k] = i_en[f_add(i_cur, k + 1)];
    end
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SW'(k);
    end
  end

  // empty mask holds the index; landing at or
  // below the old index means we went around
  always_comb begin
    o_none = ~|i_en;
    o_next = i_cur;
    o_wrap = 1'b0;
    if (!o_none) begin
      o_next = f_add(i_cur, int'(w_off) + 1);
      o_wrap = (o_next <= i_cur);
    end
  end

endmodule

// File: rtl/rr_sample_mux.sv
// rr_sample_mux: N-channel registered sample mux
// with round-robin / hold / load select sequencer.
module rr_sample_mux
  import rr_sample_mux_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int W   = 1,
  parameter  int CW  = 16,
  localparam int SW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   ch_en,
  input  logic [1:0]       mode,
  input  logic [SW-1:0]    load_sel,
  input  logic             start,
  input  logic             stop,
  rr_sample_mux_if.master  m_if,
  output logic             wrap,
  output logic             load_err,
  output logic [CW-1:0]    sample_cnt
);

  localparam logic [SW:0] NCH_V = (SW+1)'(NCH);

  state_t        r_state;
  state_t        w_nxt_state;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_osel;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_wrap;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic          w_hs;
  logic [SW-1:0] w_rr_next;
  logic          w_rr_wrap;
  logic          w_rr_none;
  logic [SW-1:0] w_sel_nxt;
  logic          w_wrap_nxt;
  logic          w_err_set;

  assign w_hs = r_valid & m_if.out_ready;

  rr_next_sel #(.NCH(NCH)) u_next (
    .i_cur  (r_sel),
    .i_en   (ch_en),
    .o_next (w_rr_next),
    .o_wrap (w_rr_wrap),
    .o_none (w_rr_none)
  );

  // next-state logic
  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_nxt_state = ST_SAMPLE;
      ST_SAMPLE: w_nxt_state = ST_WAIT;
      ST_WAIT: begin
        if (w_hs)
          w_nxt_state = stop ? ST_IDLE : ST_SAMPLE;
      end
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  // select update chosen by mode, applied at handshake
  always_comb begin
    w_sel_nxt  = r_sel;
    w_wrap_nxt = 1'b0;
    w_err_set  = 1'b0;
    unique case (1'b1)
      (mode == MODE_AUTO): begin
        w_sel_nxt  = w_rr_next;
        w_wrap_nxt = w_rr_wrap & ~w_rr_none;
      end
      (mode == MODE_LOAD): begin
        if ({1'b0, load_sel} < NCH_V)
          w_sel_nxt = load_sel;
        else
          w_err_set = 1'b1;
      end
      (mode == MODE_HOLD): w_sel_nxt = r_sel;
      default:             w_sel_nxt = r_sel;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nxt_state;
  end

  // output sample: capture in SAMPLE, drop on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_osel  <= '0;
    end else if (r_state == ST_SAMPLE) begin
      r_valid <= 1'b1;
      r_data  <= in_data[r_sel*W +: W];
      r_osel  <= r_sel;
    end else if (w_hs) begin
      r_valid <= 1'b0;
    end
  end

  // select, wrap pulse and sticky load error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_hs) begin
        r_sel  <= w_sel_nxt;
        r_wrap <= w_wrap_nxt;
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  // saturating count of accepted samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_hs && (r_cnt != '1))
      r_cnt <= r_cnt + CW'(1);
  end

  assign m_if.out_valid = r_valid;
  assign m_if.out_data  = r_data;
  assign m_if.out_sel   = r_osel;
  assign wrap           = r_wrap;
  assign load_err       = r_err;
  assign sample_cnt     = r_cnt;

endmodule

// File: tb/tb_rr_sample_mux.sv
// tb_rr_sample_mux: scoreboard bench, two configs
// (NCH=4/CW=16 and NCH=6/CW=3).
module tb_rr_sample_mux;
  import rr_sample_mux_pkg::*;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    bit         w;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q4[$];
  exp_t q6[$];

  logic        reset4 = 1'b1;
  logic [15:0] in4;
  logic [3:0]  en4;
  logic [1:0]  mode4;
  logic [1:0]  lsel4;
  logic        start4 = 1'b0;
  logic        stop4 = 1'b0;
  logic        wrap4, err4;
  logic [15:0] cnt4;

  logic        reset6 = 1'b1;
  logic [23:0] in6;
  logic [5:0]  en6;
  logic [1:0]  mode6;
  logic [2:0]  lsel6;
  logic        start6 = 1'b0;
  logic        stop6 = 1'b0;
  logic        wrap6, err6;
  logic [2:0]  cnt6;

  rr_sample_mux_if #(.W(4), .SW(2)) if4();
  rr_sample_mux_if #(.W(4), .SW(3)) if6();

  rr_sample_mux #(.NCH(4), .W(4), .CW(16)) u4 (
    .clk(clk), .reset(reset4), .in_data(in4),
    .ch_en(en4), .mode(mode4), .load_sel(lsel4),
    .start(start4), .stop(stop4), .m_if(if4),
    .wrap(wrap4), .load_err(err4), .sample_cnt(cnt4)
  );

  rr_sample_mux #(.NCH(6), .W(4), .CW(3)) u6 (
    .clk(clk), .reset(reset6), .in_data(in6),
    .ch_en(en6), .mode(mode6), .load_sel(lsel6),
    .start(start6), .stop(stop6), .m_if(if6),
    .wrap(wrap6), .load_err(err6), .sample_cnt(cnt6)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push4(input logic [3:0] d,
                       input logic [2:0] s,
                       input bit w);
    exp_t e;
    e.d = d; e.s = s; e.w = w;
    q4.push_back(e);
  endtask

  task automatic push6(input logic [3:0] d,
                       input logic [2:0] s,
                       input bit w);
    exp_t e;
    e.d = d; e.s = s; e.w = w;
    q6.push_back(e);
  endtask

  function automatic int qsz(input bit six);
    return six ? q6.size() : q4.size();
  endfunction

  task automatic wait_q(input bit six, input int sz,
                        input int budget, input string nm);
    int n = 0;
    while (qsz(six) > sz && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    n_cmp++;
    if (qsz(six) > sz) begin
      n_bad++;
      $display("FAIL %s timeout: queue %0d expected <= %0d",
               nm, qsz(six), sz);
    end
  endtask

  task automatic rst4();
    @(posedge clk); #1 reset4 = 1'b1;
    @(posedge clk); #1 reset4 = 1'b0;
  endtask

  task automatic go4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic go6();
    @(posedge clk); #1 start6 = 1'b1;
    @(posedge clk); #1 start6 = 1'b0;
  endtask

  // scoreboard monitor, NCH=4 instance
  initial begin : mon4
    exp_t e;
    bit   pend = 0;
    bit   pw = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("wrap4", 32'(wrap4), 32'(pw));
        pend = 0;
      end
      if (if4.out_valid && if4.out_ready) begin
        if (q4.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hs4: unexpected sample sel %0d data %0h",
                   if4.out_sel, if4.out_data);
        end else begin
          e = q4.pop_front();
          chk("data4", 32'(if4.out_data), 32'(e.d));
          chk("sel4", 32'(if4.out_sel), 32'(e.s));
          pend = 1; pw = e.w;
        end
      end
    end
  end

  // scoreboard monitor, NCH=6 instance
  initial begin : mon6
    exp_t e;
    bit   pend = 0;
    bit   pw = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("wrap6", 32'(wrap6), 32'(pw));
        pend = 0;
      end
      if (if6.out_valid && if6.out_ready) begin
        if (q6.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hs6: unexpected sample sel %0d data %0h",
                   if6.out_sel, if6.out_data);
        end else begin
          e = q6.pop_front();
          chk("data6", 32'(if6.out_data), 32'(e.d));
          chk("sel6", 32'(if6.out_sel), 32'(e.s));
          pend = 1; pw = e.w;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    if4.out_ready = 1'b0;
    if6.out_ready = 1'b0;
    in4 = 16'hDCBA; en4 = 4'hF;
    mode4 = MODE_HOLD; lsel4 = 2'd0;
    in6 = 24'h654321; en6 = 6'h3F;
    mode6 = MODE_HOLD; lsel6 = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset4 = 1'b0; reset6 = 1'b0;

    // reset state and idle
    @(negedge clk);
    chk("rst_valid", 32'(if4.out_valid), 0);
    chk("rst_data", 32'(if4.out_data), 0);
    chk("rst_sel", 32'(if4.out_sel), 0);
    chk("rst_wrap", 32'(wrap4), 0);
    chk("rst_err", 32'(err4), 0);
    chk("rst_cnt", 32'(cnt4), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(if4.out_valid), 0);
    end

    // AUTO sweep, all channels, always ready
    mode4 = MODE_AUTO; en4 = 4'b1111;
    if4.out_ready = 1'b1;
    push4(4'hA, 0, 0); push4(4'hB, 1, 0);
    push4(4'hC, 2, 0); push4(4'hD, 3, 1);
    push4(4'hA, 0, 0);
    go4();
    wait_q(0, 0, 40, "sweep");
    if4.out_ready = 1'b0;
    chk("sweep_cnt", 32'(cnt4), 5);

    // masked AUTO with a 5-cycle stall
    rst4();
    mode4 = MODE_AUTO; en4 = 4'b1010;
    if4.out_ready = 1'b1;
    push4(4'hA, 0, 0); push4(4'hB, 1, 0);
    push4(4'hD, 3, 1); push4(4'hB, 1, 0);
    push4(4'hD, 3, 1);
    go4();
    wait_q(0, 4, 20, "mask_first");
    if4.out_ready = 1'b0;
    n = 0;
    while (!if4.out_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("stall_valid_up", 32'(if4.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(if4.out_valid), 1);
      chk("stall_sel", 32'(if4.out_sel), 1);
      chk("stall_data", 32'(if4.out_data), 32'hB);
      if (i == 1) begin
        en4 = 4'b0101; mode4 = MODE_LOAD; lsel4 = 2'd3;
      end
    end
    @(posedge clk);
    #1 en4 = 4'b1010; mode4 = MODE_AUTO;
    if4.out_ready = 1'b1;
    wait_q(0, 0, 40, "mask_rest");
    if4.out_ready = 1'b0;

    // LOAD then HOLD, then stop and restart
    rst4();
    mode4 = MODE_LOAD; lsel4 = 2'd2; en4 = 4'hF;
    if4.out_ready = 1'b1;
    push4(4'hA, 0, 0); push4(4'hC, 2, 0);
    push4(4'hC, 2, 0); push4(4'hC, 2, 0);
    push4(4'hC, 2, 0);
    go4();
    wait_q(0, 4, 20, "load");
    mode4 = MODE_HOLD; lsel4 = 2'd3;
    wait_q(0, 1, 30, "hold");
    mode4 = MODE_AUTO; stop4 = 1'b1;
    wait_q(0, 0, 20, "stop");
    stop4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stopped_valid", 32'(if4.out_valid), 0);
    end
    chk("stop_cnt", 32'(cnt4), 5);
    mode4 = MODE_HOLD;
    push4(4'hD, 3, 0);
    go4();
    wait_q(0, 0, 20, "restart");
    if4.out_ready = 1'b0;

    // NCH=6: LOAD 5, bad LOAD 6, then HOLD to saturate
    mode6 = MODE_LOAD; lsel6 = 3'd5;
    if6.out_ready = 1'b1;
    push6(4'h1, 0, 0);
    for (int i = 0; i < 8; i++) push6(4'h6, 5, 0);
    go6();
    wait_q(1, 8, 20, "load5");
    chk("err_before", 32'(err6), 0);
    lsel6 = 3'd6;
    wait_q(1, 7, 20, "load6");
    chk("err_set", 32'(err6), 1);
    mode6 = MODE_HOLD;
    wait_q(1, 0, 60, "sat");
    if6.out_ready = 1'b0;
    chk("sat_cnt", 32'(cnt6), 7);
    chk("err_sticky", 32'(err6), 1);

    // async reset while a sample is held
    n = 0;
    while (!if6.out_valid && n < 10) begin
      @(negedge clk); n++;
    end
    chk("pre_rst_valid", 32'(if6.out_valid), 1);
    reset6 = 1'b1;
    #1;
    chk("arst_valid", 32'(if6.out_valid), 0);
    chk("arst_data", 32'(if6.out_data), 0);
    chk("arst_sel", 32'(if6.out_sel), 0);
    chk("arst_cnt", 32'(cnt6), 0);
    chk("arst_err", 32'(err6), 0);
    @(posedge clk); #1 reset6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(if6.out_valid), 0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
